// File: rtl/iq_frame_averager.sv
// iq_frame_averager: frame-checks a serialized IQ burst, averages 2^n good frames, publishes to a double-buffered bank (ports: clk, reset, iq_in/iq_stb in, log2_navg, clear, rd_addr -> rd_data, avg_stb, avg_seq, frame_err, err_cnt)
module iq_frame_averager #(
  parameter int rw = 20,
  parameter int nslot = 8,
  parameter int sw = 3,
  parameter int max_log2 = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [rw-1:0] iq_in,
  input  logic          iq_stb,
  input  logic [3:0]    log2_navg,
  input  logic          clear,
  input  logic [sw-1:0] rd_addr,
  output logic [rw-1:0] rd_data,
  output logic          avg_stb,
  output logic [15:0]   avg_seq,
  output logic          frame_err,
  output logic [15:0]   err_cnt
);
  localparam int aw = rw + max_log2;
  localparam int cw = $clog2(nslot + 2);
  localparam int iw = $clog2(nslot);
  localparam logic [cw-1:0] full = cw'(nslot);
  localparam logic [cw-1:0] over = cw'(nslot + 1);
  localparam logic [max_log2:0] one = 1;
  logic [cw-1:0] cnt;
  logic stb_d;
  logic signed [rw-1:0] capture [nslot];
  logic signed [aw-1:0] acc [nslot];
  logic signed [rw-1:0] bank [nslot];
  logic [max_log2:0] frm_cnt, cnt_next;
  logic [3:0] n, n_next;
  logic pub, burst_end, good, bad, first, reach;
  always_comb begin
    burst_end = stb_d & ~iq_stb;
    good = burst_end && cnt == full;
    bad = burst_end && cnt != full;
    first = frm_cnt == '0;
    n_next = first ? (log2_navg > 4'(max_log2) ? 4'(max_log2) : log2_navg) : n;
    cnt_next = frm_cnt + 1'b1;
    reach = cnt_next == (one << n_next);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      stb_d <= 1'b0;
      frm_cnt <= '0;
      n <= '0;
      pub <= 1'b0;
      rd_data <= '0;
      avg_stb <= 1'b0;
      avg_seq <= '0;
      frame_err <= 1'b0;
      err_cnt <= '0;
      for (int s = 0; s < nslot; s++) begin
        capture[s] <= '0;
        acc[s] <= '0;
        bank[s] <= '0;
      end
    end else begin
      stb_d <= iq_stb;
      frame_err <= bad;
      if (bad && err_cnt != 16'hffff) err_cnt <= err_cnt + 1'b1;
      // the counter saturates one past nslot so long bursts stay distinguishable from good ones
      if (burst_end) cnt <= '0;
      else if (iq_stb && cnt != over) cnt <= cnt + 1'b1;
      if (iq_stb && cnt < full) capture[cnt[iw-1:0]] <= iq_in;
      avg_stb <= 1'b0;
      if (clear) begin
        frm_cnt <= '0;
        pub <= 1'b0;
      end else begin
        if (good) begin
          for (int s = 0; s < nslot; s++) acc[s] <= first ? aw'(capture[s]) : acc[s] + aw'(capture[s]);
          n <= n_next;
          frm_cnt <= reach ? '0 : cnt_next;
        end
        pub <= good && reach;
        if (pub) begin
          for (int s = 0; s < nslot; s++) bank[s] <= rw'(acc[s] >>> n);
          avg_stb <= 1'b1;
          avg_seq <= avg_seq + 1'b1;
        end
      end
      rd_data <= 32'(rd_addr) < nslot ? bank[rd_addr[iw-1:0]] : '0;
    end
  end
endmodule

// File: tb/tb_iq_frame_averager.sv
// tb_iq_frame_averager: directed self-checking bench for iq_frame_averager
module tb_iq_frame_averager;
  localparam int rw = 20;
  localparam int sw = 4;
  logic clk = 0;
  logic reset = 1;
  logic [rw-1:0] iq_in = '0;
  logic iq_stb = 0;
  logic [3:0] log2_navg = '0;
  logic clear = 0;
  logic [sw-1:0] rd_addr = '0;
  logic [rw-1:0] rd_data;
  logic avg_stb, frame_err;
  logic [15:0] avg_seq, err_cnt;
  int errors = 0;
  int checks = 0;
  int wbuf [16];

  iq_frame_averager #(.rw(rw), .nslot(8), .sw(sw), .max_log2(12)) dut (
    .clk(clk), .reset(reset), .iq_in(iq_in), .iq_stb(iq_stb), .log2_navg(log2_navg),
    .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data), .avg_stb(avg_stb),
    .avg_seq(avg_seq), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int len);
    for (int i = 0; i < len; i++) begin
      iq_stb = 1;
      iq_in = rw'(wbuf[i]);
      tick;
    end
    iq_stb = 0;
  endtask

  task automatic burst_chk(input string tag, input int len, input logic e, input logic s);
    send(len);
    tick;
    check({tag, " frame_err"}, 32'(frame_err), 32'(e));
    check({tag, " avg_stb early"}, 32'(avg_stb), 32'(0));
    tick;
    check({tag, " avg_stb"}, 32'(avg_stb), 32'(s));
    check({tag, " frame_err off"}, 32'(frame_err), 32'(0));
  endtask

  task automatic rd(input string tag, input int a, input int exp);
    rd_addr = sw'(a);
    tick;
    check(tag, 32'($signed(rd_data)), 32'(exp));
  endtask

  task automatic fill(input int v0, input int v1, input int rest);
    for (int i = 0; i < 16; i++) wbuf[i] = rest;
    wbuf[0] = v0;
    wbuf[1] = v1;
  endtask

  initial begin
    tick;
    tick;
    check("rst rd_data", 32'(rd_data), 0);
    check("rst avg_stb", 32'(avg_stb), 0);
    check("rst avg_seq", 32'(avg_seq), 0);
    check("rst frame_err", 32'(frame_err), 0);
    check("rst err_cnt", 32'(err_cnt), 0);
    reset = 0;
    tick;

    log2_navg = 0;
    for (int i = 0; i < 8; i++) wbuf[i] = (i % 2 == 0) ? i + 1 : -(i + 1);
    burst_chk("n0", 8, 0, 1);
    tick;
    check("n0 avg_stb pulse", 32'(avg_stb), 0);
    check("n0 avg_seq", 32'(avg_seq), 1);
    for (int i = 0; i < 8; i++) rd($sformatf("n0 slot%0d", i), i, (i % 2 == 0) ? i + 1 : -(i + 1));

    log2_navg = 2;
    fill(10, -1, 0);
    burst_chk("n2 f1", 8, 0, 0);
    fill(11, -1, 0);
    burst_chk("n2 f2", 8, 0, 0);
    fill(12, -1, 0);
    burst_chk("n2 f3", 8, 0, 0);
    fill(-1, -2, 0);
    burst_chk("n2 f4", 8, 0, 1);
    check("n2 avg_seq", 32'(avg_seq), 2);
    rd("n2 slot0", 0, 8);
    rd("n2 slot1", 1, -2);
    rd("n2 slot2", 2, 0);

    fill(5, 5, 5);
    burst_chk("short", 7, 1, 0);
    burst_chk("long", 9, 1, 0);
    check("err_cnt", 32'(err_cnt), 2);
    log2_navg = 0;
    burst_chk("after err", 8, 0, 1);
    check("after err seq", 32'(avg_seq), 3);
    rd("after err slot0", 0, 5);
    rd("after err slot7", 7, 5);

    log2_navg = 12;
    for (int i = 0; i < 8; i++) wbuf[i] = (i % 2 == 0) ? 32'h7ffff : -524288;
    for (int f = 0; f < 4095; f++) burst_chk("fs", 8, 0, 0);
    burst_chk("fs last", 8, 0, 1);
    check("fs avg_seq", 32'(avg_seq), 4);
    rd("fs slot0", 0, 32'h7ffff);
    rd("fs slot1", 1, -524288);

    log2_navg = 3;
    fill(100, 100, 100);
    for (int f = 0; f < 5; f++) burst_chk("pre clr", 8, 0, 0);
    clear = 1;
    tick;
    clear = 0;
    for (int f = 1; f <= 8; f++) begin
      fill(f, -f, 0);
      burst_chk($sformatf("clr f%0d", f), 8, 0, f == 8);
      log2_navg = 0;
    end
    check("clr avg_seq", 32'(avg_seq), 5);
    rd("clr slot0", 0, 4);
    rd("clr slot1", 1, -5);

    log2_navg = 1;
    fill(3, 3, 3);
    burst_chk("pre rst", 8, 0, 0);
    iq_stb = 1;
    tick;
    tick;
    tick;
    reset = 1;
    #1;
    check("mid rst rd_data", 32'(rd_data), 0);
    check("mid rst avg_seq", 32'(avg_seq), 0);
    check("mid rst err_cnt", 32'(err_cnt), 0);
    check("mid rst avg_stb", 32'(avg_stb), 0);
    check("mid rst frame_err", 32'(frame_err), 0);
    iq_stb = 0;
    tick;
    reset = 0;
    tick;
    burst_chk("post rst f1", 8, 0, 0);
    fill(6, 6, 6);
    burst_chk("post rst f2", 8, 0, 1);
    check("post rst seq", 32'(avg_seq), 1);
    rd("post rst slot1", 1, 4);
    rd("rd_addr 9", 9, 0);
    rd("post rst slot0", 0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iq_frame_averager.md
Name: iq_frame_averager

Overview:
- Sits directly downstream of the 4-channel DDC and consumes its serialized IQ stream: a contiguous strobe_cc burst of I0, Q0, I1, Q1, ... one word per cycle.
- Checks burst framing and captures each complete frame.
- Coherently averages 2^log2_navg consecutive good frames per slot.
- Publishes the averaged frame into a double-buffered register bank that the host or processing logic reads through a random-access port.

Parameters:
- rw, 20, width of each signed input IQ word and of each averaged output word
- nslot, 8, words per frame (2 x number of channels)
- sw, 3, slot address width; must satisfy 2^sw >= nslot
- max_log2, 12, largest accepted log2_navg; accumulator width is rw+max_log2

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iq_in  in  rw  signed IQ word, valid while iq_stb is high
- iq_stb  in  1  burst strobe, wired to the DDC strobe_cc output
- log2_navg  in  4  log2 of frames per average; values above max_log2 are clamped to max_log2
- clear  in  1  synchronous restart of the current averaging run
- rd_addr  in  sw  output bank slot select
- rd_data  out  rw  signed averaged word for rd_addr, registered
- avg_stb  out  1  one-cycle pulse when a new averaged frame is published
- avg_seq  out  16  count of published frames, wraps
- frame_err  out  1  one-cycle pulse when a malformed burst is detected
- err_cnt  out  16  count of malformed bursts, saturating

Behaviour:
- Reset (asynchronous, active-high) clears all of the following:
  - slot counter, frame counter, accumulators, capture registers and output bank;
  - rd_data, avg_stb, avg_seq, frame_err and err_cnt all go to 0.
- Capture:
  - Each cycle iq_stb is high, iq_in is written to capture[slot] and slot increments.
  - The burst ends on the first cycle iq_stb is low after being high.
- Framing check at burst end:
  - The frame is good only if exactly nslot words were received.
  - For fewer or more than nslot words: pulse frame_err on the burst-end cycle, increment err_cnt (saturating at 0xFFFF), and discard the frame. Words beyond nslot are not written.
  - The slot counter returns to 0 on every burst end.
- Accumulate:
  - One cycle after a good burst end, all nslot slots are added in parallel: acc[s] <= acc[s] + sign-extended capture[s].
  - The same edge increments the frame counter.
  - On the first frame of a run, acc[s] is loaded with capture[s] rather than added.
- Run control:
  - log2_navg is latched into the run length n at the start of each run, i.e. when the first frame is accepted.
  - Changes mid-run take effect on the next run.
- Publish:
  - When the frame counter reaches 2^n, on the cycle after the final accumulate:
    - bank[s] <= acc[s] >>> n (arithmetic shift, truncation toward minus infinity; no rounding);
    - avg_stb pulses high for 1 cycle;
    - avg_seq increments;
    - the frame counter returns to 0.
  - n = 0 publishes every good frame unchanged. Latency from burst end to avg_stb is 2 cycles.
- Read port:
  - rd_data <= bank[rd_addr], 1-cycle read latency.
  - For rd_addr >= nslot, rd_data = 0.
  - The bank updates atomically on the publish edge, so a read never returns a mix of two averages.
- Overflow: the accumulator width rw+max_log2 cannot overflow for any n <= max_log2.
- Simultaneous events:
  - clear has priority over accumulate and publish. It zeroes the frame counter and marks the next good frame as a run start.
  - clear does not touch the bank, avg_seq or err_cnt.
  - A burst in progress during clear continues to be captured normally.
- A new burst may start on the cycle right after a burst end. Capture and accumulate stages are independent, so back-to-back bursts separated by one idle cycle are all processed.

Test Plan:
- log2_navg=0; good burst 1,-2,3,-4,5,-6,7,-8 -> avg_stb 2 cycles after burst end; bank reads the same values; avg_seq=1.
- log2_navg=2; 4 good frames with slot0 = 10,11,12,-1 -> slot0 reads 32>>>2 = 8; a single avg_stb after the 4th frame; slot1 frames -1,-1,-1,-2 -> -5>>>2 = -2.
- 7-word burst, then 9-word burst -> frame_err pulses twice; err_cnt=2; no accumulation or avg_stb; the next good frame is averaged normally.
- Full-scale frames 0x7FFFF and 0x80000 with log2_navg=12 for 4096 frames -> bank = 0x7FFFF and 0x80000 exactly; no wrap.
- log2_navg=3; clear asserted after 5 frames -> no publish; publish occurs after 8 further good frames and excludes the pre-clear data. Changing log2_navg mid-run does not alter the current run.
- Assert reset mid-burst and mid-run -> all outputs 0 immediately; the next 8-word burst is treated as frame 1 of a new run; rd_addr=9 reads 0.
